// File: rtl/mm_pkg.sv
// Shared Mastermind types: colour width, the NO_COLOR marker, the guess-entry
// state enum and the four-digit guess type. The feedback scorer imports it too.
package mm_pkg;

  localparam int COLOR_W = 3;
  localparam logic [COLOR_W-1:0] NO_COLOR = 3'd7;

  typedef enum logic [1:0] {
    EDIT   = 2'd0,
    COMMIT = 2'd1,
    LOCKED = 2'd2
  } guess_state_t;

  typedef logic [3:0][COLOR_W-1:0] guess_t;

  // True when no two of the four digits share a colour.
  function automatic logic all_distinct(input guess_t g);
    logic ok;
    ok = 1'b1;
    for (int a = 0; a < 4; a++) begin
      for (int b = a + 1; b < 4; b++) begin
        if (g[a] == g[b]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/guess_digit.sv
// One guess digit: COLOR_W-bit up/down counter that wraps between 0 and
// NUM_COLORS-1; it only moves while its enable is high.
module guess_digit
  import mm_pkg::*;
#(
  parameter int NUM_COLORS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               inc,
  input  logic               dec,
  output logic [COLOR_W-1:0] value
);

  localparam logic [COLOR_W-1:0] LAST = COLOR_W'(NUM_COLORS - 1);

  logic [COLOR_W-1:0] value_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_reg <= '0;
    end else if (en && inc) begin
      value_reg <= (value_reg == LAST) ? '0 : value_reg + 1'b1;
    end else if (en && dec) begin
      value_reg <= (value_reg == '0) ? LAST : value_reg - 1'b1;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/guess_entry.sv
// Mastermind player-input stage: edits a 4-digit guess from button pulses and
// commits it to the history registers. GUESS_DUP_REJECT_EN refuses guesses with repeated digits.
module guess_entry
  import mm_pkg::*;
#(
  parameter int NUM_COLORS = 6,
  parameter int MAX_TURNS  = 8,
  parameter int TURN_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_next,
  input  logic               btn_inc,
  input  logic               btn_dec,
  input  logic               btn_submit,
  input  logic               game_over,
  output logic [COLOR_W-1:0] cur0,
  output logic [COLOR_W-1:0] cur1,
  output logic [COLOR_W-1:0] cur2,
  output logic [COLOR_W-1:0] cur3,
  output logic [1:0]         sel,
  output logic [COLOR_W-1:0] history0,
  output logic [COLOR_W-1:0] history1,
  output logic [COLOR_W-1:0] history2,
  output logic [COLOR_W-1:0] history3,
  output logic [TURN_W-1:0]  turn,
  output logic               last_turn,
  output logic               guess_valid,
  output logic               reject
);

  guess_state_t      state_reg, state_next;
  logic [1:0]        sel_reg;
  guess_t            cur;
  guess_t            history_reg;
  logic [TURN_W-1:0] turn_reg;
  logic              last_turn_reg;
  logic              guess_valid_reg;
  logic              reject_reg;

  logic              edit_active;
  logic              act_submit, act_inc, act_dec, act_next;
  logic              dup_refuse, accept;
  logic [TURN_W-1:0] turn_inc;
  logic              final_turn;

  // game_over pre-empts any edit or submit in the same cycle.
  assign edit_active = (state_reg == EDIT) && !game_over;
  assign act_submit  = edit_active && btn_submit;
  assign act_inc     = edit_active && btn_inc && !btn_submit;
  assign act_dec     = edit_active && btn_dec && !btn_inc && !btn_submit;
  assign act_next    = edit_active && btn_next && !btn_dec && !btn_inc && !btn_submit;

`ifdef GUESS_DUP_REJECT_EN
  assign dup_refuse = act_submit && !all_distinct(cur);
`else
  assign dup_refuse = 1'b0;
`endif
  assign accept = act_submit && !dup_refuse;

  assign turn_inc   = turn_reg + 1'b1;
  assign final_turn = (turn_inc == TURN_W'(MAX_TURNS));

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      guess_digit #(
        .NUM_COLORS(NUM_COLORS)
      ) u_digit (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (edit_active && (sel_reg == 2'(gi))),
        .inc   (act_inc),
        .dec   (act_dec),
        .value (cur[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EDIT: begin
        if (game_over)   state_next = LOCKED;
        else if (accept) state_next = COMMIT;
      end
      COMMIT: begin
        if (final_turn || game_over) state_next = LOCKED;
        else                         state_next = EDIT;
      end
      default: state_next = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= EDIT;
      sel_reg         <= '0;
      history_reg     <= {4{NO_COLOR}};
      turn_reg        <= '0;
      last_turn_reg   <= 1'b0;
      guess_valid_reg <= 1'b0;
      reject_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      guess_valid_reg <= 1'b0;
      reject_reg      <= dup_refuse;
      if (act_next) sel_reg <= sel_reg + 1'b1;
      if (state_reg == COMMIT) begin
        history_reg     <= cur;
        turn_reg        <= turn_inc;
        guess_valid_reg <= 1'b1;
        if (final_turn) last_turn_reg <= 1'b1;
      end
    end
  end

  assign cur0        = cur[0];
  assign cur1        = cur[1];
  assign cur2        = cur[2];
  assign cur3        = cur[3];
  assign sel         = sel_reg;
  assign history0    = history_reg[0];
  assign history1    = history_reg[1];
  assign history2    = history_reg[2];
  assign history3    = history_reg[3];
  assign turn        = turn_reg;
  assign last_turn   = last_turn_reg;
  assign guess_valid = guess_valid_reg;
  assign reject      = reject_reg;

endmodule

// File: tb/tb_guess_entry.sv
// Scoreboard bench for guess_entry: a game-level model predicts every cycle's
// outputs into a queue, and a monitor compares them one cycle at a time.
module tb_guess_entry;

  localparam int NC = 6;
  localparam int MT = 8;
  localparam int TW = 4;
`ifdef GUESS_DUP_REJECT_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_submit = 1'b0, game_over = 1'b0;
  logic [2:0] cur0, cur1, cur2, cur3, history0, history1, history2, history3;
  logic [1:0] sel;
  logic [TW-1:0] turn;
  logic last_turn, guess_valid, reject;

  always #5 clk = ~clk;

  guess_entry #(.NUM_COLORS(NC), .MAX_TURNS(MT), .TURN_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_submit(btn_submit), .game_over(game_over),
    .cur0(cur0), .cur1(cur1), .cur2(cur2), .cur3(cur3), .sel(sel),
    .history0(history0), .history1(history1), .history2(history2), .history3(history3),
    .turn(turn), .last_turn(last_turn), .guess_valid(guess_valid), .reject(reject)
  );

  typedef struct packed {
    logic [3:0][2:0] cur;
    logic [1:0]      sel;
    logic [3:0][2:0] hist;
    logic [TW-1:0]   turn;
    logic            last;
    logic            gv;
    logic            rej;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int fails  = 0;
  int txn    = 0;

  // Reference model: the game as digits, a cursor, and a phase name.
  typedef enum int { M_EDIT, M_PENDING, M_LOCKED } phase_t;
  phase_t m_phase;
  int m_cur[4], m_hist[4], m_sel, m_turn;
  bit m_last, m_gv, m_rej;

  function automatic bit distinct4(input int d0, input int d1, input int d2, input int d3);
    return d0 != d1 && d0 != d2 && d0 != d3 && d1 != d2 && d1 != d3 && d2 != d3;
  endfunction

  task automatic model_step(input bit r, input bit nx, input bit ic, input bit dc,
                            input bit sb, input bit go);
    m_gv  = 1'b0;
    m_rej = 1'b0;
    if (!r) begin
      m_phase = M_EDIT; m_sel = 0; m_turn = 0; m_last = 1'b0;
      for (int i = 0; i < 4; i++) begin m_cur[i] = 0; m_hist[i] = 7; end
    end else if (m_phase == M_PENDING) begin
      for (int i = 0; i < 4; i++) m_hist[i] = m_cur[i];
      m_turn = m_turn + 1;
      m_gv   = 1'b1;
      if (m_turn == MT) m_last = 1'b1;
      m_phase = (m_turn == MT || go) ? M_LOCKED : M_EDIT;
    end else if (m_phase == M_EDIT) begin
      if (go) m_phase = M_LOCKED;
      else if (sb) begin
        if (DUP_EN && !distinct4(m_cur[0], m_cur[1], m_cur[2], m_cur[3])) m_rej = 1'b1;
        else m_phase = M_PENDING;
      end
      else if (ic) m_cur[m_sel] = (m_cur[m_sel] + 1) % NC;
      else if (dc) m_cur[m_sel] = (m_cur[m_sel] + NC - 1) % NC;
      else if (nx) m_sel = (m_sel + 1) % 4;
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    for (int i = 0; i < 4; i++) begin
      s.cur[i]  = 3'(m_cur[i]);
      s.hist[i] = 3'(m_hist[i]);
    end
    s.sel  = 2'(m_sel);
    s.turn = TW'(m_turn);
    s.last = m_last;
    s.gv   = m_gv;
    s.rej  = m_rej;
    return s;
  endfunction

  // One clock of stimulus: drive after the falling edge, predict, enqueue.
  task automatic cycle(input bit r, input bit nx, input bit ic, input bit dc,
                       input bit sb, input bit go);
    @(negedge clk);
    rst_n = r; btn_next = nx; btn_inc = ic; btn_dec = dc; btn_submit = sb; game_over = go;
    model_step(r, nx, ic, dc, sb, go);
    exp_q.push_back(model_snap());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL txn %0d %s: got %0d expected %0d", txn, name, act, req);
    end
  endtask

  // Monitor: one registered output snapshot per clock, just after the rising edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        cmp("cur0", int'(cur0), int'(e.cur[0]));
        cmp("cur1", int'(cur1), int'(e.cur[1]));
        cmp("cur2", int'(cur2), int'(e.cur[2]));
        cmp("cur3", int'(cur3), int'(e.cur[3]));
        cmp("sel", int'(sel), int'(e.sel));
        cmp("history0", int'(history0), int'(e.hist[0]));
        cmp("history1", int'(history1), int'(e.hist[1]));
        cmp("history2", int'(history2), int'(e.hist[2]));
        cmp("history3", int'(history3), int'(e.hist[3]));
        cmp("turn", int'(turn), int'(e.turn));
        cmp("last_turn", int'(last_turn), int'(e.last));
        cmp("guess_valid", int'(guess_valid), int'(e.gv));
        cmp("reject", int'(reject), int'(e.rej));
        $display("txn %0d cur=%0d%0d%0d%0d sel=%0d hist=%0d%0d%0d%0d turn=%0d last=%0d gv=%0d rej=%0d",
                 txn, cur0, cur1, cur2, cur3, sel, history0, history1, history2, history3,
                 turn, last_turn, guess_valid, reject);
      end
    end
  end

  initial begin
    model_step(0, 0, 0, 0, 0, 0);
    do_reset();
    press_inc(3);                         // cur0 -> 3
    do_reset();
    cycle(1, 0, 0, 1, 0, 0);              // dec wraps 0 -> 5
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 0);
    do_reset();
    // Enter 1,2,3,4 and submit.
    press_inc(1); cycle(1, 1, 0, 0, 0, 0);
    press_inc(2); cycle(1, 1, 0, 0, 0, 0);
    press_inc(3); cycle(1, 1, 0, 0, 0, 0);
    press_inc(4);
    cycle(1, 0, 0, 0, 1, 0);
    idle(3);
    cycle(1, 0, 1, 0, 1, 0);              // inc and submit together: only commit
    idle(2);
    // Button pulses during COMMIT are ignored.
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 1, 1, 1, 1, 0);
    idle(1);
    for (int t = 0; t < 6; t++) begin     // reach turn 8
      cycle(1, 0, 0, 0, 1, 0);
      idle(2);
    end
    press_inc(2);                         // locked: no effect
    cycle(1, 0, 0, 0, 1, 0);
    idle(2);
    // Duplicate-digit guess 2,2,0,1.
    do_reset();
    press_inc(2); cycle(1, 1, 0, 0, 0, 0);
    press_inc(2); cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    press_inc(1);
    cycle(1, 0, 0, 0, 1, 0);
    idle(3);
    // Reset asserted while in COMMIT.
    cycle(1, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    idle(2);
    // game_over in EDIT and while a commit completes.
    cycle(1, 0, 0, 0, 0, 1);
    idle(1);
    press_inc(1);
    do_reset();
    cycle(1, 0, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, 1);
    idle(2);
    do_reset();
    // Randomised play.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 6) == 0),
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 499) == 0));
    end
    idle(1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
